// File: rtl/wgt_load_scheduler.sv
// wgt_load_scheduler: splits one input stream per tile into weight beats then IFM beats and frames the run
// Ports: start + cfg_* launch a run (cfg captured at start); s_valid/s_data/s_ready input stream;
// wgt_*/ifm_* registered beat feeds gated by the buffers' full flags; tile_done advances tiles;
// op_start/end_conv frame the run, busy/tile_idx report progress, err_cfg flags a weight count not a multiple of 3.
module wgt_load_scheduler #(
  parameter int DATA_W = 512,
  parameter int CNT_W = 16,
  parameter int TILE_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_wgt_words,
  input  logic [CNT_W-1:0]  cfg_ifm_words,
  input  logic [TILE_W-1:0] cfg_tiles,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              wgt_valid,
  output logic [DATA_W-1:0] wgt_data,
  input  logic              wgt_full,
  output logic              ifm_valid,
  output logic [DATA_W-1:0] ifm_data,
  input  logic              ifm_full,
  input  logic              tile_done,
  output logic              op_start,
  output logic              end_conv,
  output logic              busy,
  output logic [TILE_W-1:0] tile_idx,
  output logic              err_cfg
);
  typedef enum logic [2:0] {IDLE, START, WGT, IFM, WAIT, END} state_t;
  state_t state_q, first_ph, after_wgt;
  logic [CNT_W-1:0] wgt_words_q, ifm_words_q, cnt_q, cnt_inc;
  logic [TILE_W-1:0] tiles_q, tile_q;
  logic [DATA_W-1:0] wgt_data_q, ifm_data_q;
  logic wgt_valid_q, ifm_valid_q, op_start_q, end_conv_q, busy_q, err_cfg_q, hs, bad_cfg;
  // first_ph is where a tile begins once empty phases are skipped
  always_comb begin
    first_ph = wgt_words_q != '0 ? WGT : ifm_words_q != '0 ? IFM : WAIT;
    after_wgt = ifm_words_q != '0 ? IFM : WAIT;
    s_ready = (state_q == WGT && !wgt_full) || (state_q == IFM && !ifm_full);
    hs = s_valid && s_ready;
    cnt_inc = cnt_q + 1'b1;
    bad_cfg = cfg_wgt_words % CNT_W'(3) != '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      wgt_words_q <= '0;
      ifm_words_q <= '0;
      tiles_q <= '0;
      tile_q <= '0;
      cnt_q <= '0;
      wgt_data_q <= '0;
      ifm_data_q <= '0;
      wgt_valid_q <= 1'b0;
      ifm_valid_q <= 1'b0;
      op_start_q <= 1'b0;
      end_conv_q <= 1'b0;
      busy_q <= 1'b0;
      err_cfg_q <= 1'b0;
    end else begin
      op_start_q <= 1'b0;
      end_conv_q <= 1'b0;
      wgt_valid_q <= 1'b0;
      ifm_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          err_cfg_q <= bad_cfg;
          if (!bad_cfg) begin
            wgt_words_q <= cfg_wgt_words;
            ifm_words_q <= cfg_ifm_words;
            tiles_q <= cfg_tiles;
            tile_q <= '0;
            cnt_q <= '0;
            busy_q <= 1'b1;
            state_q <= cfg_tiles == '0 ? END : START;
            op_start_q <= cfg_tiles != '0;
            end_conv_q <= cfg_tiles == '0;
          end
        end
        START: begin
          state_q <= first_ph;
          cnt_q <= '0;
        end
        WGT: if (hs) begin
          wgt_valid_q <= 1'b1;
          wgt_data_q <= s_data;
          cnt_q <= cnt_inc == wgt_words_q ? '0 : cnt_inc;
          if (cnt_inc == wgt_words_q) state_q <= after_wgt;
        end
        IFM: if (hs) begin
          ifm_valid_q <= 1'b1;
          ifm_data_q <= s_data;
          cnt_q <= cnt_inc == ifm_words_q ? '0 : cnt_inc;
          if (cnt_inc == ifm_words_q) state_q <= WAIT;
        end
        WAIT: if (tile_done) begin
          cnt_q <= '0;
          if (tile_q == tiles_q - 1'b1) begin
            state_q <= END;
            end_conv_q <= 1'b1;
          end else begin
            tile_q <= tile_q + 1'b1;
            state_q <= first_ph;
          end
        end
        END: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign wgt_valid = wgt_valid_q;
  assign wgt_data = wgt_data_q;
  assign ifm_valid = ifm_valid_q;
  assign ifm_data = ifm_data_q;
  assign op_start = op_start_q;
  assign end_conv = end_conv_q;
  assign busy = busy_q;
  assign tile_idx = tile_q;
  assign err_cfg = err_cfg_q;
endmodule
